// File: rtl/spi_slave.sv
// spi_slave: receive-side SPI endpoint for 16-bit packets.
// It shifts in a 16-bit command on MOSI and, in the same SS_n-low frame, shifts out a
// 16-bit response on MISO.
// Bus format: SCLK idles high. MOSI is sampled on the SCLK rise, MISO is updated on the
// SCLK fall, and data is MSB first. All SPI pins are asynchronous to clk.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   SS_n      slave select, active-low frame (async)
//   SCLK      serial clock, idle high (async)
//   MOSI      serial command data (async)
//   MISO      serial response data, tx_shft[15] during a frame, else 0
//   tx_data   response word, captured at SS_n fall
//   cmd_rcvd  last complete command, held until the next good frame
//   rdy       one-clk pulse when cmd_rcvd is updated
//   err       one-clk pulse when a frame ends with bit count != 16
module spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [15:0] tx_data,
  output logic        MISO,
  output logic [15:0] cmd_rcvd,
  output logic        rdy,
  output logic        err
);

  typedef enum logic [1:0] {StWaitHi, StIdle, StFrame} state_e;

  // Synchronizer chains: bit 0 is ff1, bit 1 is ff2, bit 2 is the history flop.
  logic [2:0] sclk_ff_q;
  logic [2:0] ss_ff_q;
  logic [1:0] mosi_ff_q;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_sync, mosi_sync;

  state_e      state_q;
  logic [1:0]  settle_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] tx_shft_q;
  logic [15:0] rx_shft_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_ff_q <= 3'b111;
      ss_ff_q   <= 3'b111;
      mosi_ff_q <= 2'b00;
    end else begin
      sclk_ff_q <= {sclk_ff_q[1:0], SCLK};
      ss_ff_q   <= {ss_ff_q[1:0], SS_n};
      mosi_ff_q <= {mosi_ff_q[0], MOSI};
    end
  end

  always_comb begin
    sclk_rise = sclk_ff_q[1] & ~sclk_ff_q[2];
    sclk_fall = ~sclk_ff_q[1] & sclk_ff_q[2];
    ss_rise   = ss_ff_q[1] & ~ss_ff_q[2];
    ss_fall   = ~ss_ff_q[1] & ss_ff_q[2];
    ss_sync   = ss_ff_q[1];
    // MOSI comes from ff2, so it has the same delay as the SCLK edge detect.
    mosi_sync = mosi_ff_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StWaitHi;
      settle_q  <= 2'd0;
      bit_cnt_q <= 5'd0;
      tx_shft_q <= 16'h0000;
      rx_shft_q <= 16'h0000;
      cmd_rcvd  <= 16'h0000;
      rdy       <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state_q)
        StWaitHi: begin
          // The SS_n chain still holds its reset ones right after reset.
          // Judging SS_n before real pin samples reach ff2 would let a low SS_n
          // look like a fresh fall, so let the chain fill for two clocks first.
          if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
          end else if (ss_sync) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (ss_fall) begin
            tx_shft_q <= tx_data;
            bit_cnt_q <= 5'd0;
            rx_shft_q <= 16'h0000;
            state_q   <= StFrame;
          end
        end
        StFrame: begin
          // When both happen in one cycle, the end of the frame wins and the SCLK edge is dropped.
          if (ss_rise) begin
            if (bit_cnt_q == 5'd16) begin
              cmd_rcvd <= rx_shft_q;
              rdy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            if (sclk_rise) begin
              rx_shft_q <= {rx_shft_q[14:0], mosi_sync};
              // The count stops at 17 so that an overlong frame cannot wrap back to 16.
              if (bit_cnt_q != 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (sclk_fall) begin
              tx_shft_q <= {tx_shft_q[14:0], 1'b0};
            end
          end
        end
        default: state_q <= StWaitHi;
      endcase
    end
  end

  assign MISO = (state_q == StFrame) & tx_shft_q[15];

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [15:0] tx_data;
  logic        MISO;
  logic [15:0] cmd_rcvd;
  logic        rdy;
  logic        err;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .cmd_rcvd (cmd_rcvd),
    .rdy      (rdy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [15:0] cmd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] model_cmd = 16'h0000;
  time         t_rise = 0;
  int          chg_at_bit = -1;
  logic [15:0] chg_val = 16'h0000;
  int          rst_at_bit = -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master model at 1:32.
  // SCLK drops together with SS_n, which is the idle-to-active transition, so the slave ignores
  // that edge. After that come rise/fall pairs 16 clk apart. MOSI changes at each fall, and
  // MISO is sampled just before each rise.
  task automatic frame(input logic [15:0] cmd, input int nbits, input bit expect_evt,
                       output logic [15:0] rd);
    logic [15:0] r;
    r    = 16'h0000;
    SS_n = 1'b0;
    SCLK = 1'b0;
    MOSI = cmd[15];
    for (int i = 0; i < nbits; i++) begin
      tick(16);
      r    = {r[14:0], MISO};
      SCLK = 1'b1;
      if (i == chg_at_bit) tx_data = chg_val;
      if (i == rst_at_bit) begin
        tick(4);
        rst_n = 1'b0;
        model_cmd = 16'h0000;
        tick(2);
        rst_n = 1'b1;
      end
      if (i < nbits - 1) begin
        tick(16);
        SCLK = 1'b0;
        MOSI = (i + 1 < 16) ? cmd[14 - i] : 1'b0;
      end
    end
    tick(16);
    if (expect_evt) begin
      if (nbits == 16) begin
        model_cmd = cmd;
        sb.push_back('{is_err: 1'b0, cmd: cmd});
      end else begin
        sb.push_back('{is_err: 1'b1, cmd: model_cmd});
      end
    end
    SS_n   = 1'b1;
    t_rise = $time;
    rd     = r;
    tick(8);
  endtask

  // Pops the scoreboard on each rdy/err pulse.
  always @(negedge clk) begin
    if (rdy === 1'b1 || err === 1'b1) begin
      exp_t e;
      chk("rdy_err_exclusive", {15'd0, rdy & err}, 16'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {15'd0, err}, {15'd0, ~err});
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_err", {15'd0, err}, {15'd0, e.is_err});
        chk("cmd_rcvd", cmd_rcvd, e.cmd);
        chk("pulse_latency_clk", 16'(($time - t_rise) / 10), 16'd3);
      end
    end
  end

  logic [15:0] rd;

  initial begin
    rst_n   = 1'b0;
    SS_n    = 1'($urandom_range(0, 1));
    SCLK    = 1'($urandom_range(0, 1));
    MOSI    = 1'($urandom_range(0, 1));
    tx_data = 16'($urandom);
    tick(2);
    chk("reset_MISO", {15'd0, MISO}, 16'd0);
    chk("reset_cmd_rcvd", cmd_rcvd, 16'h0000);
    chk("reset_rdy", {15'd0, rdy}, 16'd0);
    chk("reset_err", {15'd0, err}, 16'd0);
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("idle_MISO", {15'd0, MISO}, 16'd0);

    // Nominal frame.
    tx_data = 16'h3C5A;
    frame(16'hA5C3, 16, 1'b1, rd);
    chk("nominal_rd_data", rd, 16'h3C5A);
    tick(4);
    chk("nominal_cmd_hold", cmd_rcvd, 16'hA5C3);

    // Back-to-back frames, with tx_data changed partway through the first one.
    tx_data    = 16'hC3A5;
    chg_at_bit = 4;
    chg_val    = 16'h0001;
    frame(16'h1234, 16, 1'b1, rd);
    chk("b2b1_rd_data", rd, 16'hC3A5);
    chg_at_bit = -1;
    frame(16'hFFFF, 16, 1'b1, rd);
    chk("b2b2_rd_data", rd, 16'h0001);
    tick(4);
    chk("b2b_cmd_final", cmd_rcvd, 16'hFFFF);

    // Short and long frames.
    frame(16'h5555, 8, 1'b1, rd);
    tick(4);
    chk("short_cmd_retained", cmd_rcvd, 16'hFFFF);
    frame(16'h6666, 20, 1'b1, rd);
    tick(4);
    chk("long_cmd_retained", cmd_rcvd, 16'hFFFF);

    // SCLK toggles while the slave is deselected.
    for (int p = 0; p < 40; p++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
      tick(16);
      if (p % 10 == 0) chk("deselect_MISO", {15'd0, MISO}, 16'd0);
      SCLK = 1'b1;
      tick(16);
    end
    chk("deselect_cmd_unchanged", cmd_rcvd, 16'hFFFF);
    tx_data = 16'h9A9A;
    frame(16'h0F0F, 16, 1'b1, rd);
    chk("deselect_rd_data", rd, 16'h9A9A);
    tick(4);
    chk("deselect_then_good", cmd_rcvd, 16'h0F0F);

    // Reset after bit 7. The master completes the frame, and the slave reports nothing for it.
    rst_at_bit = 7;
    frame(16'h7777, 16, 1'b0, rd);
    rst_at_bit = -1;
    chk("post_reset_cmd", cmd_rcvd, 16'h0000);
    tx_data = 16'h1357;
    frame(16'hBEEF, 16, 1'b1, rd);
    chk("after_reset_rd_data", rd, 16'h1357);
    tick(4);
    chk("after_reset_cmd", cmd_rcvd, 16'hBEEF);

    tick(10);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
